// File: rtl/cache_port_arbiter.sv
// Two-port (fetch / data) arbiter in front of the single-ported cache, with a stall watchdog.
// Optional round-robin arbitration is enabled by defining ARB_ROUND_ROBIN_EN; default is fixed data priority.
module cache_port_arbiter #(
  parameter int ADDR_W        = 10,
  parameter int DATA_W        = 32,
  parameter int STALL_TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] WoreAddress,
  output logic [DATA_W-1:0] DataIn,
  input  logic              stall,
  input  logic [DATA_W-1:0] DataOut,
  output logic              err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  // err sets on the stalled edge that brings the count up to STALL_TIMEOUT
  localparam logic [15:0] TIMEOUT_M1 = 16'(STALL_TIMEOUT - 1);

  logic [1:0]        stateReg;
  logic [1:0]        stateNext;
  logic              cmdIdReg;      // 1 = data port owns the access
  logic              cmdWeReg;
  logic [ADDR_W-1:0] cmdAddrReg;
  logic [DATA_W-1:0] cmdDataReg;
  logic [15:0]       stallCntReg;
  logic              errReg;
  logic [DATA_W-1:0] ifRdataReg;
  logic [DATA_W-1:0] dRdataReg;
  logic              grantData;
  logic              anyReq;

`ifdef ARB_ROUND_ROBIN_EN
  logic              lastGrantReg;  // 1 = data won the previous arbitration
`endif

  assign anyReq = if_req | d_req;

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    if (if_req && d_req) begin
      grantData = ~lastGrantReg;
    end else begin
      grantData = d_req;
    end
`else
    grantData = d_req;
`endif
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (anyReq) stateNext = ACCESS;
      ACCESS:  if (!stall) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stateReg    <= IDLE;
      cmdIdReg    <= 1'b0;
      cmdWeReg    <= 1'b0;
      cmdAddrReg  <= '0;
      cmdDataReg  <= '0;
      stallCntReg <= '0;
      errReg      <= 1'b0;
      ifRdataReg  <= '0;
      dRdataReg   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      lastGrantReg <= 1'b1;
`endif
    end else begin
      stateReg <= stateNext;
      case (stateReg)
        IDLE: begin
          if (anyReq) begin
            cmdIdReg    <= grantData;
            cmdWeReg    <= grantData & d_we;
            cmdAddrReg  <= grantData ? d_addr : if_addr;
            cmdDataReg  <= grantData ? d_wdata : '0;
            stallCntReg <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            lastGrantReg <= grantData;
`endif
          end
        end
        ACCESS: begin
          if (stall) begin
            if (stallCntReg != 16'hFFFF) stallCntReg <= stallCntReg + 16'd1;
            if (stallCntReg >= TIMEOUT_M1) errReg <= 1'b1;
          end else if (!cmdWeReg) begin
            if (cmdIdReg) dRdataReg <= DataOut;
            else          ifRdataReg <= DataOut;
          end
        end
        default: ;
      endcase
    end
  end

  // All outputs come from registers so stall/DataOut never reach them combinationally
  assign MemRead     = (stateReg == ACCESS) && !cmdWeReg;
  assign MemWrite    = (stateReg == ACCESS) && cmdWeReg;
  assign WoreAddress = cmdAddrReg;
  assign DataIn      = cmdDataReg;
  assign if_done     = (stateReg == DONE) && !cmdIdReg;
  assign d_done      = (stateReg == DONE) && cmdIdReg;
  assign if_rdata    = ifRdataReg;
  assign d_rdata     = dRdataReg;
  assign err         = errReg;

endmodule
